fetch_align: RTL
================

Name: fetch_align

Overview:
- Instruction fetch aligner and sequencer that sits between instruction memory and the decode stage.
- Requests 64-bit aligned words from memory and keeps a 128-bit parcel buffer.
- Presents a top-aligned 64-bit instruction window plus its PC to decode. Instruction length (16/32/64 bits) is derived from the window's top bits.
- On each decode handshake it retires exactly one instruction; on flush it redirects fetch to a new PC.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset; must be 2-byte aligned.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  redirect request; discards all buffered and in-flight fetch state
- flush_pc  in  64  target PC for flush; bit 0 ignored
- mem_req  out  1  fetch request
- mem_addr  out  64  fetch address; bits [2:0] always 0
- mem_ack  in  1  memory accepts mem_addr and returns mem_data in the same cycle
- mem_data  in  64  fetched word; byte at mem_addr is in bits [63:56]
- inst_out  out  64  decode window = buf[127:64]
- inst_pc  out  64  PC of the instruction at inst_out[63:48]
- inst_len  out  2  1 = 16-bit, 2 = 32-bit, 3 = 64-bit; decoded from inst_out[63:62]
- inst_valid  out  1  a complete instruction is present in the window
- dec_ready  in  1  decode consumes the instruction this cycle

Behaviour:
- State:
  - buf[127:0], parcel-packed; the oldest 16-bit parcel is in buf[127:112].
  - cnt[3:0], valid parcels, range 0..8.
  - fetch_addr[63:0].
  - skip[1:0], leading parcels to drop from the next accepted word.
  - pc[63:0].
- Reset (rst high at a clock edge):
  - buf = 0, cnt = 0, fetch_addr = {RESET_PC[63:3], 3'b0}, skip = RESET_PC[2:1], pc = RESET_PC.
  - Outputs while cnt = 0: inst_valid = 0, inst_out = 0, inst_pc = RESET_PC, mem_req = 0 while rst is high.
- Length decode:
  - need = 1 if buf[127] = 0; need = 2 if buf[127:126] = 2'b10; need = 4 if buf[127:126] = 2'b11.
  - inst_len is combinational from buf[127:126].
- inst_valid = (cnt >= need) & (cnt != 0) & ~flush & ~rst.
- fire = inst_valid & dec_ready.
  - Shift buf left by 16*need bits, zero-fill, cnt -= need, pc += 2*need.
- mem_req = (cnt <= 4) & ~flush & ~rst. This is combinational from registered cnt, so there is always room for a full word.
- Memory handshake: mem_addr = fetch_addr; held stable while mem_req & ~mem_ack.
- accept = mem_req & mem_ack.
  - fetch_addr += 8.
  - Drop the top skip parcels of mem_data, then clear skip to 0.
  - Append the remaining (4 - skip) parcels directly below the valid parcels.
- Same cycle fire and accept: consume first, then append at the post-consume cnt.
  - cnt_next = cnt - need + 4 - skip.
  - cnt never exceeds 8.
- flush (priority over fire and accept; ignored only under rst):
  - cnt = 0, buf = 0.
  - fetch_addr = {flush_pc[63:3], 3'b0}, skip = flush_pc[2:1], pc = {flush_pc[63:1], 1'b0}.
  - Any mem_ack in the flush cycle is ignored; mem_req is already low.
- Instructions straddling a word boundary are assembled transparently. inst_valid stays low until all parcels are present.
- Stall (dec_ready = 0): inst_out, inst_pc and inst_len stay stable. The buffer keeps filling until cnt > 4, then mem_req drops.
- Wrap-around: fetch_addr and pc wrap modulo 2^64 with no special handling.
- rst has priority over flush.

Test Plan:
1. Reset, dec_ready = 1, memory returns 64'h1111_2222_3333_4444 at addr 0 -> inst_out[63:48] = 1111, 2222, 3333, 4444 on consecutive fires; inst_pc = 0, 2, 4, 6; inst_len = 1.
2. Word0 = 64'hA000_0001_C000_0000, word1 = 64'h0000_0002_1234_5678 -> 32-bit A0000001 at pc 0, then 64-bit C0000000_00000002 (straddles boundary) at pc 4, then 16-bit 1234 at pc 0xC.
3. dec_ready = 0 for 10 cycles with continuous mem_ack -> exactly two accepts; cnt = 8; mem_req = 0; inst_out and inst_pc unchanged; resumes correctly when dec_ready = 1.
4. flush with flush_pc = 64'h106 -> next mem_addr = 64'h100; first three parcels dropped; inst_pc = 64'h106; window holds parcel [15:0] of that word.
5. flush asserted in the same cycle as mem_ack and dec_ready = 1 -> data discarded; pc not incremented; inst_valid = 0 that cycle; next mem_addr = aligned flush_pc.
6. Assert rst mid-stream with cnt = 6 -> next cycle cnt = 0, inst_valid = 0, inst_pc = RESET_PC, mem_addr = aligned RESET_PC.

Source files
------------

// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - instruction fetch aligner: 64-bit memory words in, top-aligned 16/32/64-bit instructions out
module fetch_align #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [63:0] flush_pc,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_data,
  output logic [63:0] inst_out,
  output logic [63:0] inst_pc,
  output logic [1:0]  inst_len,
  output logic        inst_valid,
  input  logic        dec_ready
);

  logic [127:0] pbuf;
  logic [3:0]   cnt;
  logic [63:0]  fetch_addr;
  logic [1:0]   skip;
  logic [63:0]  pc;

  logic [3:0]   need;
  logic         fire;
  logic         accept;
  logic [127:0] buf_shift;
  logic [3:0]   cnt_shift;
  logic [63:0]  word_trim;
  logic [127:0] word_ext;

  always_comb begin
    inst_len = 2'd1;
    need     = 4'd1;
    if (pbuf[127]) begin
      inst_len = pbuf[126] ? 2'd3 : 2'd2;
      need     = pbuf[126] ? 4'd4 : 4'd2;
    end
  end

  assign inst_valid = (cnt >= need) && (cnt != 4'd0) && !flush && !rst;
  // Requesting only at cnt <= 4 guarantees a whole word always fits.
  assign mem_req    = (cnt <= 4'd4) && !flush && !rst;
  assign fire       = inst_valid && dec_ready;
  assign accept     = mem_req && mem_ack;

  assign inst_out = pbuf[127:64];
  assign inst_pc  = pc;
  assign mem_addr = fetch_addr;

  // Consume first, then append the trimmed word below the surviving parcels.
  always_comb begin
    buf_shift = fire ? (pbuf << {need, 4'b0}) : pbuf;
    cnt_shift = fire ? (cnt - need) : cnt;
    word_trim = mem_data << {skip, 4'b0};
    word_ext  = {word_trim, 64'b0} >> {cnt_shift, 4'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pbuf       <= '0;
      cnt        <= 4'd0;
      fetch_addr <= {RESET_PC[63:3], 3'b0};
      skip       <= RESET_PC[2:1];
      pc         <= RESET_PC;
    end else if (flush) begin
      pbuf       <= '0;
      cnt        <= 4'd0;
      fetch_addr <= {flush_pc[63:3], 3'b0};
      skip       <= flush_pc[2:1];
      pc         <= flush_pc & ~64'd1;
    end else begin
      if (fire)
        pc <= pc + {59'b0, need, 1'b0};
      if (accept) begin
        pbuf       <= buf_shift | word_ext;
        cnt        <= cnt_shift + 4'd4 - {2'b0, skip};
        fetch_addr <= fetch_addr + 64'd8;
        skip       <= 2'd0;
      end else begin
        pbuf <= buf_shift;
        cnt  <= cnt_shift;
      end
    end
  end

endmodule
